// File: rtl/panel_controller.sv
// -----------------------------------------------------------------------------
// panel_controller
//
// Front-panel controller. Raw buttons are synchronised, debounced and turned
// into single-cycle press pulses. The presses drive three things:
//   * register load strobes (write / clear of the C, SELECT and START regs),
//   * a run FSM (IDLE/RUN) that issues do_start / do_clear_pulse to the pulse
//     unit and optionally auto-continues after each instruction,
//   * a memory FSM (MIDLE/MREAD/MWRITE) that drives a manual memory port.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   btn_*                      raw asynchronous push buttons
//   switch_*                   level switches (2-flop synchronised inside)
//   input_reg_c_value          31-bit panel word (bit 30 = sign)
//   input_reg_select_value     12-bit panel address
//   input_reg_start_value      12-bit panel address
//   reg_start_value            live program counter
//   instruction_finish         end-of-instruction pulse from the pulse unit
//   mem_finish                 memory completion pulse
//   do_start, do_clear_pulse   one-cycle commands to the pulse unit
//   do_arr_reg_*, arr_reg_*_data  register load strobes and load data
//   mem_read_enable, mem_write_enable, mem_addr, mem_write_data  memory port
//   running, panel_mem_active  status
// -----------------------------------------------------------------------------
module panel_controller #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_machine_start,
   input  logic        btn_clear_pulse,
   input  logic        btn_do_read_mem,
   input  logic        btn_do_write_mem,
   input  logic        btn_write_reg,
   input  logic        btn_clear_reg_c,
   input  logic        btn_clear_reg_select,
   input  logic        btn_clear_reg_start,
   input  logic        switch_auto_enable,
   input  logic        switch_stop_at_enable,
   input  logic        switch_select_or_start,
   input  logic        switch_arr_reg_c,
   input  logic        switch_arr_reg_select,
   input  logic        switch_arr_reg_start,
   input  logic [30:0] input_reg_c_value,
   input  logic [11:0] input_reg_select_value,
   input  logic [11:0] input_reg_start_value,
   input  logic [11:0] reg_start_value,
   input  logic        instruction_finish,
   input  logic        mem_finish,
   output logic        do_start,
   output logic        do_clear_pulse,
   output logic        do_arr_reg_c,
   output logic        do_arr_reg_select,
   output logic        do_arr_reg_start,
   output logic [30:0] arr_reg_c_data,
   output logic [11:0] arr_reg_select_data,
   output logic [11:0] arr_reg_start_data,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [11:0] mem_addr,
   output logic [30:0] mem_write_data,
   output logic        running,
   output logic        panel_mem_active
);

   localparam int NB = 8;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Button bit positions inside the button vectors
   localparam int B_START     = 0;
   localparam int B_CLR_PULSE = 1;
   localparam int B_READ      = 2;
   localparam int B_WRITE     = 3;
   localparam int B_WRITE_REG = 4;
   localparam int B_CLR_C     = 5;
   localparam int B_CLR_SEL   = 6;
   localparam int B_CLR_ST    = 7;

   // -------------------------------------------------------------------------
   // Button synchronisers, debounce and press detection
   // -------------------------------------------------------------------------
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] bsync1_q, bsync2_q;
   logic [NB-1:0] level_q, level_d;
   logic [NB-1:0] level_dly_q;
   logic [NB-1:0] press_q, press_d;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];

   assign btn_raw = {btn_clear_reg_start, btn_clear_reg_select, btn_clear_reg_c,
                     btn_write_reg, btn_do_write_mem, btn_do_read_mem,
                     btn_clear_pulse, btn_machine_start};

   // The counter only runs while the synchronised sample disagrees with the
   // accepted level; a sample that agrees again restarts it from zero. The
   // level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         level_d[i] = level_q[i];
         cnt_d[i]   = '0;
         if (bsync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = bsync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // Rising edge of the accepted level, one cycle after it flips
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bsync1_q    <= '0;
         bsync2_q    <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         press_q     <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         bsync1_q    <= btn_raw;
         bsync2_q    <= bsync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Switch synchronisers
   // -------------------------------------------------------------------------
   logic [5:0] ssync1_q, ssync2_q;
   logic       sw_auto, sw_stop_at, sw_sel_or_start, sw_arr_c, sw_arr_sel, sw_arr_st;

   always_ff @(posedge clk) begin
      if (reset) begin
         ssync1_q <= '0;
         ssync2_q <= '0;
      end else begin
         ssync1_q <= {switch_arr_reg_start, switch_arr_reg_select, switch_arr_reg_c,
                      switch_select_or_start, switch_stop_at_enable, switch_auto_enable};
         ssync2_q <= ssync1_q;
      end
   end

   assign sw_auto         = ssync2_q[0];
   assign sw_stop_at      = ssync2_q[1];
   assign sw_sel_or_start = ssync2_q[2];
   assign sw_arr_c        = ssync2_q[3];
   assign sw_arr_sel      = ssync2_q[4];
   assign sw_arr_st       = ssync2_q[5];

   // -------------------------------------------------------------------------
   // Register load strobes. They are registered from press_d so that they are
   // visible in the same cycle as the press pulse itself. A clear forces the
   // strobe with zero data and overrides a simultaneous write.
   // -------------------------------------------------------------------------
   logic        arr_c_stb_q,   arr_c_stb_d;
   logic        arr_sel_stb_q, arr_sel_stb_d;
   logic        arr_st_stb_q,  arr_st_stb_d;
   logic [30:0] arr_c_dat_q,   arr_c_dat_d;
   logic [11:0] arr_sel_dat_q, arr_sel_dat_d;
   logic [11:0] arr_st_dat_q,  arr_st_dat_d;

   always_comb begin
      arr_c_stb_d   = press_d[B_CLR_C]   | (press_d[B_WRITE_REG] & sw_arr_c);
      arr_sel_stb_d = press_d[B_CLR_SEL] | (press_d[B_WRITE_REG] & sw_arr_sel);
      arr_st_stb_d  = press_d[B_CLR_ST]  | (press_d[B_WRITE_REG] & sw_arr_st);

      arr_c_dat_d   = '0;
      arr_sel_dat_d = '0;
      arr_st_dat_d  = '0;
      if (arr_c_stb_d && !press_d[B_CLR_C]) begin
         arr_c_dat_d = input_reg_c_value;
      end
      if (arr_sel_stb_d && !press_d[B_CLR_SEL]) begin
         arr_sel_dat_d = input_reg_select_value;
      end
      if (arr_st_stb_d && !press_d[B_CLR_ST]) begin
         arr_st_dat_d = input_reg_start_value;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arr_c_stb_q   <= 1'b0;
         arr_sel_stb_q <= 1'b0;
         arr_st_stb_q  <= 1'b0;
         arr_c_dat_q   <= '0;
         arr_sel_dat_q <= '0;
         arr_st_dat_q  <= '0;
      end else begin
         arr_c_stb_q   <= arr_c_stb_d;
         arr_sel_stb_q <= arr_sel_stb_d;
         arr_st_stb_q  <= arr_st_stb_d;
         arr_c_dat_q   <= arr_c_dat_d;
         arr_sel_dat_q <= arr_sel_dat_d;
         arr_st_dat_q  <= arr_st_dat_d;
      end
   end

   // -------------------------------------------------------------------------
   // Run FSM
   // -------------------------------------------------------------------------
   typedef enum logic {R_IDLE, R_RUN} run_state_t;
   typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE} mem_state_t;

   run_state_t  run_state_q;
   mem_state_t  mem_state_q;
   logic        do_start_q, do_clear_pulse_q;
   logic        mem_accept, start_ok, auto_continue;

   // A memory press accepted in the same cycle as a start press takes the
   // panel; the start is then treated as arriving while memory is busy.
   assign mem_accept    = (press_q[B_READ] | press_q[B_WRITE]) &
                          (mem_state_q == M_IDLE) & (run_state_q == R_IDLE);
   assign start_ok      = press_q[B_START] & (mem_state_q == M_IDLE) & ~mem_accept;
   assign auto_continue = sw_auto & ~(sw_stop_at & (reg_start_value == input_reg_start_value));

   always_ff @(posedge clk) begin
      if (reset) begin
         run_state_q      <= R_IDLE;
         do_start_q       <= 1'b0;
         do_clear_pulse_q <= 1'b0;
      end else begin
         do_start_q       <= 1'b0;
         do_clear_pulse_q <= 1'b0;
         if (press_q[B_CLR_PULSE]) begin
            // Clear overrides everything, including a coincident finish
            do_clear_pulse_q <= 1'b1;
            run_state_q      <= R_IDLE;
         end else begin
            case (run_state_q)
               R_IDLE: begin
                  if (start_ok) begin
                     do_start_q  <= 1'b1;
                     run_state_q <= R_RUN;
                  end
               end
               R_RUN: begin
                  if (instruction_finish) begin
                     if (auto_continue) begin
                        do_start_q <= 1'b1;
                     end else begin
                        run_state_q <= R_IDLE;
                     end
                  end
               end
               default: run_state_q <= R_IDLE;
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Memory FSM. Address and write data are only loaded on acceptance, so they
   // stay frozen for the whole transfer.
   // -------------------------------------------------------------------------
   logic        mem_rd_q, mem_wr_q;
   logic [11:0] mem_addr_q;
   logic [30:0] mem_wdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_state_q <= M_IDLE;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (mem_state_q)
            M_IDLE: begin
               if (mem_accept) begin
                  mem_addr_q <= sw_sel_or_start ? input_reg_select_value : input_reg_start_value;
                  // Read wins over a coincident write
                  if (press_q[B_READ]) begin
                     mem_state_q <= M_READ;
                     mem_rd_q    <= 1'b1;
                  end else begin
                     mem_state_q <= M_WRITE;
                     mem_wr_q    <= 1'b1;
                     mem_wdata_q <= input_reg_c_value;
                  end
               end
            end
            M_READ: begin
               if (mem_finish) begin
                  mem_state_q <= M_IDLE;
                  mem_rd_q    <= 1'b0;
               end
            end
            M_WRITE: begin
               if (mem_finish) begin
                  mem_state_q <= M_IDLE;
                  mem_wr_q    <= 1'b0;
               end
            end
            default: begin
               mem_state_q <= M_IDLE;
               mem_rd_q    <= 1'b0;
               mem_wr_q    <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign do_start            = do_start_q;
   assign do_clear_pulse      = do_clear_pulse_q;
   assign do_arr_reg_c        = arr_c_stb_q;
   assign do_arr_reg_select   = arr_sel_stb_q;
   assign do_arr_reg_start    = arr_st_stb_q;
   assign arr_reg_c_data      = arr_c_dat_q;
   assign arr_reg_select_data = arr_sel_dat_q;
   assign arr_reg_start_data  = arr_st_dat_q;
   assign mem_read_enable     = mem_rd_q;
   assign mem_write_enable    = mem_wr_q;
   assign mem_addr            = mem_addr_q;
   assign mem_write_data      = mem_wdata_q;
   assign running             = (run_state_q == R_RUN);
   assign panel_mem_active    = (mem_state_q != M_IDLE);

endmodule

// File: tb/tb_panel_controller.sv
// -----------------------------------------------------------------------------
// tb_panel_controller
//
// Self-checking bench for panel_controller. Output pulses are logged with the
// cycle they appear in; expectations come from the behavioural rules: a clean
// press yields a pulse DB+3 cycles after the raw rise, FSM commands one cycle
// after that, register strobes carry the switch/clear selected data, and the
// memory port latches its address/data on acceptance.
// -----------------------------------------------------------------------------
module tb_panel_controller;

   localparam int DB = 4;

   localparam int B_START     = 0;
   localparam int B_CLR_PULSE = 1;
   localparam int B_READ      = 2;
   localparam int B_WRITE     = 3;
   localparam int B_WRITE_REG = 4;
   localparam int B_CLR_C     = 5;

   // Event kinds in the log
   localparam int K_START = 0;
   localparam int K_CLRP  = 1;
   localparam int K_ARR   = 2;   // 2: C, 3: SELECT, 4: START

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [7:0]  btn;
   logic        sw_auto, sw_stop, sw_sos, sw_c, sw_sel, sw_st;
   logic [30:0] in_c;
   logic [11:0] in_sel, in_st, reg_st;
   logic        ifin, mfin;

   logic        do_start, do_clear_pulse;
   logic        do_arr_reg_c, do_arr_reg_select, do_arr_reg_start;
   logic [30:0] arr_reg_c_data;
   logic [11:0] arr_reg_select_data, arr_reg_start_data;
   logic        mem_read_enable, mem_write_enable;
   logic [11:0] mem_addr;
   logic [30:0] mem_write_data;
   logic        running, panel_mem_active;

   panel_controller #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .btn_machine_start      (btn[0]),
      .btn_clear_pulse        (btn[1]),
      .btn_do_read_mem        (btn[2]),
      .btn_do_write_mem       (btn[3]),
      .btn_write_reg          (btn[4]),
      .btn_clear_reg_c        (btn[5]),
      .btn_clear_reg_select   (btn[6]),
      .btn_clear_reg_start    (btn[7]),
      .switch_auto_enable     (sw_auto),
      .switch_stop_at_enable  (sw_stop),
      .switch_select_or_start (sw_sos),
      .switch_arr_reg_c       (sw_c),
      .switch_arr_reg_select  (sw_sel),
      .switch_arr_reg_start   (sw_st),
      .input_reg_c_value      (in_c),
      .input_reg_select_value (in_sel),
      .input_reg_start_value  (in_st),
      .reg_start_value        (reg_st),
      .instruction_finish     (ifin),
      .mem_finish             (mfin),
      .do_start               (do_start),
      .do_clear_pulse         (do_clear_pulse),
      .do_arr_reg_c           (do_arr_reg_c),
      .do_arr_reg_select      (do_arr_reg_select),
      .do_arr_reg_start       (do_arr_reg_start),
      .arr_reg_c_data         (arr_reg_c_data),
      .arr_reg_select_data    (arr_reg_select_data),
      .arr_reg_start_data     (arr_reg_start_data),
      .mem_read_enable        (mem_read_enable),
      .mem_write_enable       (mem_write_enable),
      .mem_addr               (mem_addr),
      .mem_write_data         (mem_write_data),
      .running                (running),
      .panel_mem_active       (panel_mem_active)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;
      logic [30:0] data;
   } ev_t;
   ev_t ev_q[$];

   function automatic void push_ev(input int k, input logic [30:0] d);
      ev_t e;
      e.cyc  = cyc;
      e.kind = k;
      e.data = d;
      ev_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (do_start)          push_ev(K_START, 31'd0);
      if (do_clear_pulse)    push_ev(K_CLRP, 31'd0);
      if (do_arr_reg_c)      push_ev(K_ARR + 0, arr_reg_c_data);
      if (do_arr_reg_select) push_ev(K_ARR + 1, {19'd0, arr_reg_select_data});
      if (do_arr_reg_start)  push_ev(K_ARR + 2, {19'd0, arr_reg_start_data});
   end

   function automatic int n_ev(input int k);
      int n = 0;
      for (int i = 0; i < ev_q.size(); i++) if (ev_q[i].kind == k) n++;
      return n;
   endfunction

   function automatic int n_ev_at(input int k, input int c);
      int n = 0;
      for (int i = 0; i < ev_q.size(); i++) if (ev_q[i].kind == k && ev_q[i].cyc == c) n++;
      return n;
   endfunction

   function automatic logic [30:0] ev_data(input int k);
      for (int i = 0; i < ev_q.size(); i++) if (ev_q[i].kind == k) return ev_q[i].data;
      return '1;
   endfunction

   function automatic logic [127:0] all_outs();
      return {21'd0, do_start, do_clear_pulse, do_arr_reg_c, do_arr_reg_select,
              do_arr_reg_start, arr_reg_c_data, arr_reg_select_data, arr_reg_start_data,
              mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
              running, panel_mem_active};
   endfunction

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold a button mask for `hold` cycles, release, let the release settle
   task automatic tap(input logic [7:0] mask, input int hold, output int t0);
      btn = mask;
      t0  = cyc;
      tick(hold);
      btn = '0;
      tick(DB + 6);
   endtask

   logic m_run;   // reference: run FSM in RUN

   task automatic fin_step(input logic [11:0] rv);
      int   tf;
      logic cont;
      reg_st = rv;
      ev_q.delete();
      ifin = 1'b1;
      tf   = cyc;
      tick(1);
      ifin = 1'b0;
      cont = m_run && sw_auto && !(sw_stop && (rv == in_st));
      check_val("run_after_finish", 128'(running), 128'(cont));
      tick(1);
      check_val("auto_do_start", 128'(n_ev_at(K_START, tf + 1)), 128'(cont));
      m_run = cont;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          t0, glen, hold, rr;
      logic [2:0]  sw3, clr3;
      logic        wr, is_read;
      logic [30:0] val [3];
      logic [11:0] e_addr;
      logic [30:0] e_wdata;
      logic [7:0]  mask;

      reset = 1'b1; btn = '0;
      sw_auto = 0; sw_stop = 0; sw_sos = 0; sw_c = 0; sw_sel = 0; sw_st = 0;
      in_c = '0; in_sel = '0; in_st = '0; reg_st = '0; ifin = 0; mfin = 0;
      m_run = 1'b0; e_wdata = '0; e_addr = '0;
      tick(3);
      check_val("reset_outputs", all_outs(), 128'd0);
      reset = 1'b0;
      tick(2);

      // Glitch then clean press of machine_start
      for (int it = 0; it < 4; it++) begin
         tap(8'(1 << B_CLR_PULSE), DB + 2, t0);
         ev_q.delete();
         glen = $urandom_range(1, DB - 1);
         btn[B_START] = 1'b1; tick(glen); btn[B_START] = 1'b0;
         tick($urandom_range(3, 8));
         hold = (it == 0) ? 40 : $urandom_range(DB + 1, 40);
         tap(8'(1 << B_START), hold, t0);
         check_val("start_count", 128'(n_ev(K_START)), 128'd1);
         check_val("start_latency", 128'(n_ev_at(K_START, t0 + DB + 4)), 128'd1);
         check_val("running_after_start", 128'(running), 128'd1);
      end
      m_run = 1'b1;

      // Register write / clear strobes; first pass is the fixed C-register case
      for (int it = 0; it < 8; it++) begin
         if (it == 0) begin
            sw3 = 3'b001; clr3 = 3'b000; wr = 1'b1;
            val[0] = 31'h4000_0005; val[1] = 12'h0; val[2] = 12'h0;
         end else begin
            sw3  = 3'($urandom_range(0, 7));
            clr3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
            wr   = 1'($urandom_range(0, 1));
            if (clr3 == 3'b000) wr = 1'b1;
            val[0] = 31'($urandom);
            val[1] = 31'($urandom_range(0, 4095));
            val[2] = 31'($urandom_range(0, 4095));
         end
         sw_c = sw3[0]; sw_sel = sw3[1]; sw_st = sw3[2];
         in_c = val[0]; in_sel = val[1][11:0]; in_st = val[2][11:0];
         tick(3);
         ev_q.delete();
         mask = 8'({clr3, wr} << B_WRITE_REG);
         tap(mask, DB + 2, t0);
         for (int r = 0; r < 3; r++) begin
            logic exp_stb;
            exp_stb = clr3[r] | (wr & sw3[r]);
            check_val($sformatf("arr%0d_strobe", r), 128'(n_ev(K_ARR + r)), 128'(exp_stb));
            if (exp_stb) begin
               check_val($sformatf("arr%0d_timing", r), 128'(n_ev_at(K_ARR + r, t0 + DB + 3)), 128'd1);
               check_val($sformatf("arr%0d_data", r), 128'(ev_data(K_ARR + r)),
                         128'(clr3[r] ? 31'd0 : val[r]));
            end
         end
      end

      // Auto mode: fixed 1,2,3 sequence, then randomized steps
      tap(8'(1 << B_CLR_PULSE), DB + 2, t0);
      m_run = 1'b0;
      check_val("idle_after_clear", 128'(running), 128'd0);
      sw_auto = 1'b1; sw_stop = 1'b1; in_st = 12'h003;
      tick(3);
      tap(8'(1 << B_START), DB + 2, t0);
      m_run = 1'b1;
      check_val("run_entered", 128'(running), 128'd1);
      fin_step(12'h001);
      ev_q.delete();
      tap(8'(1 << B_START), DB + 2, t0);
      check_val("start_ignored_in_run", 128'(n_ev(K_START)), 128'd0);
      fin_step(12'h002);
      fin_step(12'h003);
      for (int it = 0; it < 10; it++) begin
         if (!m_run) begin
            tap(8'(1 << B_START), DB + 2, t0);
            m_run = 1'b1;
            check_val("run_reentered", 128'(running), 128'd1);
         end
         sw_auto = 1'($urandom_range(0, 1));
         sw_stop = 1'($urandom_range(0, 1));
         in_st   = 12'($urandom_range(0, 3));
         tick(3);
         fin_step(12'($urandom_range(0, 3)));
      end

      // Clear coinciding with instruction_finish in auto mode
      if (!m_run) begin
         tap(8'(1 << B_START), DB + 2, t0);
         m_run = 1'b1;
      end
      sw_auto = 1'b1; sw_stop = 1'b0;
      tick(3);
      ev_q.delete();
      btn[B_CLR_PULSE] = 1'b1;
      t0 = cyc;
      tick(DB + 3);
      ifin = 1'b1; tick(1); ifin = 1'b0;
      tick(1);
      check_val("clear_pulse_issued", 128'(n_ev_at(K_CLRP, t0 + DB + 4)), 128'd1);
      check_val("clear_beats_finish", 128'(n_ev(K_START)), 128'd0);
      check_val("clear_forces_idle", 128'(running), 128'd0);
      btn = '0;
      tick(DB + 6);
      m_run = 1'b0;

      // Memory transfers with dropped presses while busy
      for (int it = 0; it < 5; it++) begin
         int op;
         op = (it == 0) ? 0 : $urandom_range(0, 2);
         sw_sos = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         in_sel = (it == 0) ? 12'h07F : 12'($urandom);
         in_st  = 12'($urandom);
         in_c   = 31'($urandom);
         tick(3);
         is_read = (op != 1);
         mask = (op == 0) ? 8'(1 << B_READ) :
                (op == 1) ? 8'(1 << B_WRITE) : 8'((1 << B_READ) | (1 << B_WRITE));
         e_addr = sw_sos ? in_sel : in_st;
         if (!is_read) e_wdata = in_c;
         btn = mask;
         tick(DB + 4);
         check_val("mem_rd_en", 128'(mem_read_enable), 128'(is_read));
         check_val("mem_wr_en", 128'(mem_write_enable), 128'(!is_read));
         check_val("mem_addr", 128'(mem_addr), 128'(e_addr));
         check_val("mem_active", 128'(panel_mem_active), 128'd1);
         if (!is_read) check_val("mem_wdata", 128'(mem_write_data), 128'(e_wdata));
         btn = '0;
         tick(DB + 6);
         ev_q.delete();
         btn = is_read ? 8'((1 << B_WRITE) | (1 << B_START)) : 8'((1 << B_READ) | (1 << B_START));
         tick(DB + 6);
         btn = '0;
         in_sel = 12'($urandom); in_st = 12'($urandom); in_c = 31'($urandom);
         tick(DB + 6);
         check_val("busy_rd_held", 128'(mem_read_enable), 128'(is_read));
         check_val("busy_wr_held", 128'(mem_write_enable), 128'(!is_read));
         check_val("busy_addr_held", 128'(mem_addr), 128'(e_addr));
         check_val("busy_wdata_held", 128'(mem_write_data), 128'(e_wdata));
         check_val("busy_start_ignored", 128'(n_ev(K_START)), 128'd0);
         mfin = 1'b1; tick(1); mfin = 1'b0;
         check_val("done_rd_low", 128'(mem_read_enable), 128'd0);
         check_val("done_wr_low", 128'(mem_write_enable), 128'd0);
         check_val("done_idle", 128'(panel_mem_active), 128'd0);
         tick(2);
      end

      // Reset in the middle of a write, start button held through reset
      sw_sos = 1'b0;
      tick(3);
      btn = 8'(1 << B_WRITE);
      tick(DB + 4);
      check_val("write_before_reset", 128'(mem_write_enable), 128'd1);
      btn = 8'(1 << B_START);
      reset = 1'b1;
      tick(1);
      check_val("reset_drops_write", 128'(mem_write_enable), 128'd0);
      check_val("reset_all_outputs", all_outs(), 128'd0);
      tick(2);
      ev_q.delete();
      reset = 1'b0;
      rr = cyc;
      tick(DB + 8);
      check_val("held_through_reset_count", 128'(n_ev(K_START)), 128'd1);
      check_val("held_through_reset_time", 128'(n_ev_at(K_START, rr + DB + 4)), 128'd1);
      btn = '0;
      tick(DB + 6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/panel_controller.md
PANEL_CONTROLLER -- requirements
Module: panel_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a new button level.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem, btn_write_reg, btn_clear_reg_c, btn_clear_reg_select, btn_clear_reg_start  input  1 each  raw asynchronous front-panel buttons.
REQ-005 switch_auto_enable, switch_stop_at_enable, switch_select_or_start, switch_arr_reg_c, switch_arr_reg_select, switch_arr_reg_start  input  1 each  level switches, used after a 2-flop synchroniser.
REQ-006 input_reg_c_value  input  31  panel word; bit 30 is the sign.
REQ-007 input_reg_select_value, input_reg_start_value  input  12 each  panel addresses.
REQ-008 reg_start_value  input  12  live start (program counter) register.
REQ-009 instruction_finish  input  1  one-cycle pulse from the pulse unit at the end of an instruction.
REQ-010 mem_finish  input  1  memory completion pulse.
REQ-011 do_start, do_clear_pulse  output  1 each  one-cycle commands to the pulse unit.
REQ-012 do_arr_reg_c/do_arr_reg_select/do_arr_reg_start  output  1 each; arr_reg_c_data 31, arr_reg_select_data 12, arr_reg_start_data 12  register-load strobes and their data.
REQ-013 mem_read_enable, mem_write_enable  output  1 each; mem_addr 12; mem_write_data 31  manual memory port.
REQ-014 running, panel_mem_active  output  1 each  status.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser and then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples; any differing sample restarts the count.
REQ-016 A rising edge of a debounced level SHALL produce exactly one single-cycle internal press pulse; the pulse SHALL occur exactly DEBOUNCE_CYCLES+3 cycles after the raw rise for a clean press; releases produce no pulse.
REQ-017 On a write_reg press, each register whose arr switch is 1 SHALL receive a strobe in the same cycle, with data = the corresponding input value; registers whose switch is 0 are untouched.
REQ-018 A clear_reg_x press SHALL strobe do_arr_reg_x with all-zero data regardless of its switch; if clear and write_reg for the same register hit the same cycle, clear wins.
REQ-019 The run FSM has states IDLE and RUN; in IDLE a machine_start press SHALL assert do_start the next cycle and enter RUN; running = (state == RUN).
REQ-020 In RUN, on instruction_finish:
- if switch_auto_enable=1 and NOT (switch_stop_at_enable=1 and reg_start_value == input_reg_start_value), assert do_start the next cycle and stay in RUN;
- otherwise return to IDLE.
REQ-021 A machine_start press while in RUN SHALL be ignored.
REQ-022 A clear_pulse press SHALL assert do_clear_pulse the next cycle and force IDLE from any state; if simultaneous with instruction_finish, clear wins and no do_start is issued.
REQ-023 The memory FSM has states MIDLE, MREAD and MWRITE; a read or write press is accepted only in MIDLE with the run FSM in IDLE; otherwise it is dropped.
REQ-024 On acceptance, latch mem_addr = switch_select_or_start ? input_reg_select_value : input_reg_start_value, and latch mem_write_data = input_reg_c_value for a write.
REQ-025 The matching enable SHALL hold high from the cycle after acceptance until the cycle mem_finish is sampled, then drop next cycle, returning to MIDLE; panel_mem_active = (state != MIDLE).
REQ-026 If read and write presses coincide, read wins.
REQ-027 A machine_start press while panel_mem_active=1 SHALL be ignored.
REQ-028 The latched mem_addr and mem_write_data SHALL not change while the memory FSM is active.

Reset
REQ-029 While reset is high at a clock edge:
- all outputs SHALL be 0;
- both FSMs SHALL enter IDLE/MIDLE;
- debounced levels, counters and synchronisers SHALL clear to 0.
REQ-030 Reset mid-transfer SHALL drop the memory enables on the reset edge; a button held through reset yields one press pulse DEBOUNCE_CYCLES+3 cycles after reset falls.

Verification
REQ-031 Button glitch shorter than DEBOUNCE_CYCLES, then clean 40-cycle press -> exactly one do_start, at DEBOUNCE_CYCLES+4 cycles after the clean rise (press pulse at +3, do_start one cycle later).
REQ-032 switch_arr_reg_c=1, switch_arr_reg_start=0, input_reg_c_value=0x4000_0005, write_reg press -> do_arr_reg_c=1 for one cycle with arr_reg_c_data=0x4000_0005; no start strobe.
REQ-033 Auto mode: auto=1, stop_at=1, input_reg_start_value=0x003; three instruction_finish pulses with reg_start_value 0x001, 0x002, 0x003 -> do_start after the first two, IDLE after the third.
REQ-034 Read press with switch_select_or_start=1, input_reg_select_value=0x07F -> mem_read_enable high with mem_addr=0x07F until mem_finish, then low; a write press during the busy period is dropped.
REQ-035 clear_pulse and instruction_finish in the same cycle with auto=1 -> do_clear_pulse=1, no do_start, running=0.
REQ-036 Reset asserted during MWRITE -> mem_write_enable=0 on the reset edge; all outputs 0.
